matrix_addsub_stream: RTL and testbench

MATRIX_ADDSUB_STREAM -- requirements
Module: matrix_addsub_stream

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/matrix_addsub_stream_if.sv | 33 +++
 rtl/elem_addsub.sv | 25 ++
 rtl/matrix_addsub_stream.sv | 125 ++++++++++++
 tb/tb_matrix_addsub_stream.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the matrix add/sub/accumulate stream: operation modes,
// FSM states and the index-width helper.
package matrix_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_ACC = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Row/column index width; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_addsub_stream_if.sv
// Element stream bundle: input beat handshake, result handshake and status.
interface matrix_addsub_stream_if
   import matrix_pkg::*;
#(
   parameter int W  = 3,
   parameter int OW = 4,
   parameter int IW = 1
);
   mode_e           mode;
   logic            clr_acc;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_a;
   logic [W-1:0]    in_b;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_data;
   logic [IW-1:0]   out_row;
   logic [IW-1:0]   out_col;
   logic            out_last;
   logic            ovf;
   logic            busy;

   modport master (
      output mode, clr_acc, in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_row, out_col, out_last, ovf, busy
   );

   modport slave (
      input  mode, clr_acc, in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_row, out_col, out_last, ovf, busy
   );
endinterface

// File: rtl/elem_addsub.sv
// Combinational element adder/subtractor at OW = W+G bits; carry is the
// add carry-out or the subtract borrow.
module elem_addsub #(
   parameter int W = 3,
   parameter int G = 1
) (
   input  logic [W+G-1:0] a,
   input  logic [W+G-1:0] b,
   input  logic           sub,
   output logic [W+G-1:0] result,
   output logic           carry
);
   localparam int OW = W + G;

   logic [OW:0] full;

   always_comb begin
      if (sub) full = {1'b0, a} - {1'b0, b};
      else     full = {1'b0, a} + {1'b0, b};
   end

   assign result = full[OW-1:0];
   assign carry  = full[OW];

endmodule

// File: rtl/matrix_addsub_stream.sv
// Streams N x N matrices element by element (row-major), producing ADD, SUB or
// per-element accumulated results through a single output register.
module matrix_addsub_stream
   import matrix_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 3,
   parameter int G = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   matrix_addsub_stream_if.slave bus
);
   localparam int OW = W + G;
   localparam int IW = idx_width(N);
   localparam int NN = N * N;
   localparam int AW = $clog2(NN);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_e          state, state_nxt;
   mode_e           mode_q, mode_cur;
   logic [IW-1:0]   row, col;
   logic [AW-1:0]   flat;
   logic            accept, last_beat;
   logic [OW-1:0]   acc [NN];
   logic [OW-1:0]   op_a, op_b, result;
   logic            do_sub, carry;

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_beat    = (row == LAST_IDX) && (col == LAST_IDX);
   assign flat         = AW'(row) * AW'(N) + AW'(col);
   assign bus.busy     = (state == ST_STREAM);

   // The first beat of a matrix uses the live mode; later beats the latched one.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      mode_cur = (state == ST_IDLE) ? bus.mode : mode_q;
      if (mode_cur == MODE_RSV) mode_cur = MODE_ADD;
   end

   // An accumulate beat coinciding with clr_acc starts from zero.
   always_comb begin
      op_a   = OW'(bus.in_a);
      op_b   = OW'(bus.in_b);
      do_sub = (mode_cur == MODE_SUB);
      if (mode_cur == MODE_ACC) op_b = bus.clr_acc ? '0 : acc[flat];
   end

   elem_addsub #(.W(W), .G(G)) u_arith (
      .a      (op_a),
      .b      (op_b),
      .sub    (do_sub),
      .result (result),
      .carry  (carry)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept)              state_nxt = ST_STREAM;
         ST_STREAM: if (accept && last_beat) state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         mode_q <= MODE_ADD;
         row    <= '0;
         col    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            if (state == ST_IDLE) mode_q <= bus.mode;
            if (col == LAST_IDX) begin
               col <= '0;
               row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_row   <= '0;
         bus.out_col   <= '0;
         bus.out_last  <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= result;
         bus.out_row   <= row;
         bus.out_col   <= col;
         bus.out_last  <= last_beat;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // clr_acc drops earlier overflow history; an overflow on the same beat still sets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.ovf <= 1'b0;
      else        bus.ovf <= (bus.clr_acc ? 1'b0 : bus.ovf) | (accept & carry);
   end

   // NOTE: the accumulator is a register array, not a RAM, so it is reset and
   // cleared in a single cycle; the later non-blocking write lets the accepted
   // entry win over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NN; i++) acc[i] <= '0;
      end else begin
         if (bus.clr_acc) begin
            for (int i = 0; i < NN; i++) acc[i] <= '0;
         end
         if (accept && (mode_cur == MODE_ACC)) acc[flat] <= result;
      end
   end

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Directed bench for matrix_addsub_stream (N=2, W=3, G=1) with an integer
// reference model checked on every output handshake.
module tb_matrix_addsub_stream;
   import matrix_pkg::*;

   localparam int N  = 2;
   localparam int W  = 3;
   localparam int G  = 1;
   localparam int OW = W + G;
   localparam int NN = N * N;

   typedef struct {
      int data;
      int row;
      int col;
      int last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   matrix_addsub_stream_if #(.W(W), .OW(OW), .IW(1)) bus ();

   matrix_addsub_stream #(.N(N), .W(W), .G(G)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int   m_acc [NN];
   int   m_pos, m_mode, m_ovf;
   exp_t exp_q [$];
   int   got_q [$];
   bit   stall_prev;
   int   held_data, held_row, held_col, held_last;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NN; i++) m_acc[i] = 0;
      m_pos = 0;
      m_mode = 0;
      m_ovf = 0;
      exp_q.delete();
      got_q.delete();
      stall_prev = 0;
   endtask

   // Monitor: outputs and inputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 0;
      end else begin
         int   a, b, r, p, ov;
         bit   acc_beat, accepted;
         exp_t e;
         check("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
         check("ovf", int'(bus.ovf), m_ovf);
         check("busy", int'(bus.busy), int'(m_pos != 0));
         if (stall_prev) begin
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_data", int'(bus.out_data), held_data);
            check("hold_row", int'(bus.out_row), held_row);
            check("hold_col", int'(bus.out_col), held_col);
            check("hold_last", int'(bus.out_last), held_last);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", int'(bus.out_data), e.data);
               check("out_row", int'(bus.out_row), e.row);
               check("out_col", int'(bus.out_col), e.col);
               check("out_last", int'(bus.out_last), e.last);
            end
            got_q.push_back(int'(bus.out_data));
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held_data  = int'(bus.out_data);
         held_row   = int'(bus.out_row);
         held_col   = int'(bus.out_col);
         held_last  = int'(bus.out_last);

         accepted = bus.in_valid && bus.in_ready;
         acc_beat = 0;
         r = 0;
         ov = 0;
         p = m_pos;
         if (accepted) begin
            a = int'(bus.in_a);
            b = int'(bus.in_b);
            if (m_pos == 0) m_mode = (int'(bus.mode) == 3) ? 0 : int'(bus.mode);
            case (m_mode)
               1: begin r = (a - b) & ((1 << OW) - 1); ov = int'(a < b); end
               2: begin
                  r = (bus.clr_acc ? 0 : m_acc[p]) + a;
                  ov = int'(r >= (1 << OW));
                  r = r % (1 << OW);
                  acc_beat = 1;
               end
               default: begin r = a + b; ov = int'(r >= (1 << OW)); r = r % (1 << OW); end
            endcase
            e.data = r;
            e.row  = p / N;
            e.col  = p % N;
            e.last = int'(p == NN - 1);
            exp_q.push_back(e);
            m_pos = (m_pos + 1) % NN;
         end
         if (bus.clr_acc) begin
            for (int i = 0; i < NN; i++) m_acc[i] = 0;
            m_ovf = 0;
         end
         if (acc_beat) m_acc[p] = r;
         if (ov != 0) m_ovf = 1;
      end
   end

   task automatic send(input int a, input int b, input int m, input bit clr);
      int t;
      bit hs;
      bus.in_valid = 1'b1;
      bus.in_a     = 3'(a);
      bus.in_b     = 3'(b);
      bus.mode     = mode_e'(m[1:0]);
      bus.clr_acc  = clr;
      t = 0;
      hs = 0;
      while (!hs && t < 50) begin
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      bus.in_valid = 1'b0;
      bus.clr_acc  = 1'b0;
      if (!hs) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   task automatic send_matrix(input int a [NN], input int b [NN], input int m0, input int mrest,
                              input int clr_at);
      got_q.delete();
      for (int i = 0; i < NN; i++) send(a[i], b[i], (i == 0) ? m0 : mrest, i == clr_at);
      wait_drain();
   endtask

   task automatic check_got(input string name, input int e [NN]);
      check({name, "_count"}, got_q.size(), NN);
      for (int i = 0; i < NN; i++) begin
         if (i < got_q.size()) check(name, got_q[i], e[i]);
      end
   endtask

   task automatic pulse_clr();
      bus.clr_acc = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_acc = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_out_row", int'(bus.out_row), 0);
      check("rst_out_col", int'(bus.out_col), 0);
      check("rst_out_last", int'(bus.out_last), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      check("rst_busy", int'(bus.busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.mode      = MODE_ADD;
      bus.clr_acc   = 1'b0;
      bus.out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      apply_reset();

      // ADD; mode changes after the first beat must be ignored.
      send_matrix('{2, 3, 4, 5}, '{1, 2, 3, 4}, 0, 1, -1);
      check_got("add_basic", '{3, 5, 7, 9});
      check("add_basic_ovf", int'(bus.ovf), 0);

      send_matrix('{7, 7, 7, 7}, '{1, 1, 1, 1}, 0, 0, -1);
      check_got("add_carry", '{8, 8, 8, 8});
      check("add_carry_ovf", int'(bus.ovf), 0);

      send_matrix('{2, 5, 0, 7}, '{3, 2, 1, 7}, 1, 1, -1);
      check_got("sub", '{15, 3, 15, 0});
      check("sub_ovf", int'(bus.ovf), 1);

      // Reserved mode behaves as ADD; ovf stays sticky.
      send_matrix('{1, 2, 3, 4}, '{1, 1, 1, 1}, 3, 3, -1);
      check_got("rsv_add", '{2, 3, 4, 5});
      check("rsv_ovf_sticky", int'(bus.ovf), 1);

      // Backpressure: hold out_ready low for 3 cycles after the first beat.
      got_q.delete();
      send(1, 1, 0, 1'b0);
      bus.out_ready = 1'b0;
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join_none
      #1;
      check("bp_in_ready_low", int'(bus.in_ready), 0);
      send(2, 1, 0, 1'b0);
      send(3, 1, 0, 1'b0);
      send(4, 1, 0, 1'b0);
      wait_drain();
      check_got("backpressure", '{2, 3, 4, 5});

      pulse_clr();
      check("clr_ovf", int'(bus.ovf), 0);
      send_matrix('{7, 7, 7, 7}, '{0, 0, 0, 0}, 2, 2, -1);
      check_got("acc1", '{7, 7, 7, 7});
      send_matrix('{7, 7, 7, 7}, '{5, 5, 5, 5}, 2, 2, -1);
      check_got("acc2", '{14, 14, 14, 14});
      check("acc2_ovf", int'(bus.ovf), 0);
      send_matrix('{7, 7, 7, 7}, '{0, 0, 0, 0}, 2, 2, -1);
      check_got("acc3", '{5, 5, 5, 5});
      check("acc3_ovf", int'(bus.ovf), 1);

      // Reset in the middle of a matrix.
      send(2, 1, 0, 1'b0);
      send(3, 2, 0, 1'b0);
      check("busy_mid", int'(bus.busy), 1);
      apply_reset();
      send_matrix('{2, 3, 4, 5}, '{1, 2, 3, 4}, 0, 0, -1);
      check_got("post_reset_add", '{3, 5, 7, 9});

      // Accumulator must have been zeroed by reset.
      send_matrix('{1, 1, 1, 1}, '{0, 0, 0, 0}, 2, 2, -1);
      check_got("acc_after_reset", '{1, 1, 1, 1});

      // clr_acc together with an accepted ACC beat on element 1.
      send_matrix('{2, 2, 2, 2}, '{0, 0, 0, 0}, 2, 2, 1);
      check_got("acc_clr_same", '{3, 2, 2, 2});
      check("acc_clr_same_ovf", int'(bus.ovf), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
